// File: rtl/python_align_pkg.sv
// Shared codes, state types and sync legality check
// for the PYTHON300 link-alignment sequencer.
package python_align_pkg;

  localparam logic [9:0] TRAIN  = 10'h3a6;
  localparam logic [9:0] FS     = 10'h2aa;
  localparam logic [9:0] FE     = 10'h3aa;
  localparam logic [9:0] LS     = 10'h0aa;
  localparam logic [9:0] LE     = 10'h12a;
  localparam logic [9:0] DATA   = 10'h035;
  localparam logic [9:0] CRC    = 10'h059;
  localparam logic [9:0] OPB_S  = 10'h22a;
  localparam logic [9:0] OPB    = 10'h015;
  localparam logic [9:0] LE_ALT = 10'h32a;

  typedef enum logic [2:0] {
    L_IDLE, L_CHECK, L_SLIP,
    L_SETTLE, L_LOCKED, L_FAIL
  } lane_state_t;

  typedef enum logic [2:0] {
    IDLE, ALIGN, WAIT_FE, RUN, FAIL
  } state_t;

  function automatic logic is_legal_sync(
    input logic [9:0] w
  );
    return w inside {TRAIN, OPB_S, OPB, LE,
                     LE_ALT, FS, FE, LS,
                     DATA, CRC};
  endfunction

endpackage

// File: rtl/python_align_lane.sv
// Per-lane bitslip word aligner: slip, settle,
// re-check until the training word repeats.
module python_align_lane
  import python_align_pkg::*;
#(
  parameter int SETTLE_WORDS = 8,
  parameter int LOCK_COUNT   = 16,
  parameter int MAX_SLIPS    = 10
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       clear,
  input  logic       valid,
  input  logic [9:0] word,
  output logic       bitslip,
  output logic       locked,
  output logic       failed
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(SETTLE_WORDS + 1);
  localparam int XW = $clog2(MAX_SLIPS + 1);

  lane_state_t   state, state_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [SW-1:0] settle_cnt, settle_n;
  logic [XW-1:0] slip_cnt, slip_n;

  always_comb begin
    state_n  = state;
    match_n  = match_cnt;
    settle_n = settle_cnt;
    slip_n   = slip_cnt;
    if (clear) begin
      state_n  = L_CHECK;
      match_n  = '0;
      settle_n = '0;
      slip_n   = '0;
    end else begin
      unique case (state)
        L_CHECK: if (valid) begin
          if (word == TRAIN) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MW'(LOCK_COUNT - 1))
              state_n = L_LOCKED;
          end else begin
            match_n = '0;
            state_n = (slip_cnt == XW'(MAX_SLIPS))
                    ? L_FAIL : L_SLIP;
          end
        end
        L_SLIP: begin
          slip_n   = slip_cnt + 1'b1;
          settle_n = '0;
          state_n  = L_SETTLE;
        end
        L_SETTLE: if (valid) begin
          settle_n = settle_cnt + 1'b1;
          if (settle_cnt == SW'(SETTLE_WORDS - 1))
            state_n = L_CHECK;
        end
        default: ;
      endcase
    end
  end

  // outputs are decoded from the next state so
  // they line up with the state flop
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= L_IDLE;
      match_cnt  <= '0;
      settle_cnt <= '0;
      slip_cnt   <= '0;
      bitslip    <= 1'b0;
      locked     <= 1'b0;
      failed     <= 1'b0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      settle_cnt <= settle_n;
      slip_cnt   <= slip_n;
      bitslip    <= (state_n == L_SLIP);
      locked     <= (state_n == L_LOCKED);
      failed     <= (state_n == L_FAIL);
    end
  end

endmodule

// File: rtl/python_align_ctrl.sv
// PYTHON300 link-alignment sequencer: aligns five
// lanes, opens the stream gate at a frame end.
module python_align_ctrl
  import python_align_pkg::*;
#(
  parameter int SETTLE_WORDS = 8,
  parameter int LOCK_COUNT   = 16,
  parameter int MAX_SLIPS    = 10,
  parameter int ERR_LIMIT    = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic [3:0][9:0] s_data,
  input  logic [9:0]      s_sync,
  input  logic            s_valid,
  output logic [4:0]      bitslip,
  output logic [4:0]      lane_locked,
  output logic            busy,
  output logic            fail,
  output logic            stream_enable,
  output logic [15:0]     relock_count
);

  localparam int EW = $clog2(ERR_LIMIT + 1);

  state_t          state, state_n;
  logic [EW-1:0]   illegal_cnt, illegal_n;
  logic [15:0]     relock_n;
  logic            clear;
  logic [4:0]      lane_fail;
  logic [4:0][9:0] words;

  assign words = {s_sync, s_data};

  for (genvar i = 0; i < 5; i++) begin : g_lane
    python_align_lane #(
      .SETTLE_WORDS (SETTLE_WORDS),
      .LOCK_COUNT   (LOCK_COUNT),
      .MAX_SLIPS    (MAX_SLIPS)
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (clear),
      .valid   (s_valid),
      .word    (words[i]),
      .bitslip (bitslip[i]),
      .locked  (lane_locked[i]),
      .failed  (lane_fail[i])
    );
  end

  // clear is combinational so lanes restart on the
  // same edge the top enters ALIGN
  always_comb begin
    state_n   = state;
    illegal_n = illegal_cnt;
    relock_n  = relock_count;
    clear     = 1'b0;
    unique case (state)
      IDLE, FAIL: if (start) begin
        clear   = 1'b1;
        state_n = ALIGN;
      end
      ALIGN: begin
        if (|lane_fail)
          state_n = FAIL;
        else if (&lane_locked)
          state_n = WAIT_FE;
      end
      WAIT_FE: if (s_valid && s_sync == FE) begin
        illegal_n = '0;
        state_n   = RUN;
      end
      RUN: begin
        if (start) begin
          clear   = 1'b1;
          state_n = ALIGN;
        end else if (s_valid) begin
          if (is_legal_sync(s_sync)) begin
            illegal_n = '0;
          end else begin
            illegal_n = illegal_cnt + 1'b1;
            if (illegal_cnt == EW'(ERR_LIMIT - 1)) begin
              illegal_n = '0;
              clear     = 1'b1;
              state_n   = ALIGN;
              if (relock_count != 16'hffff)
                relock_n = relock_count + 16'd1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      illegal_cnt   <= '0;
      relock_count  <= '0;
      busy          <= 1'b0;
      fail          <= 1'b0;
      stream_enable <= 1'b0;
    end else begin
      state         <= state_n;
      illegal_cnt   <= illegal_n;
      relock_count  <= relock_n;
      busy          <= (state_n == ALIGN) ||
                       (state_n == WAIT_FE);
      fail          <= (state_n == FAIL);
      stream_enable <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_python_align_ctrl.sv
// Directed/random bench for python_align_ctrl with a
// rotating-lane channel model and a sync-error model.
module tb_python_align_ctrl;

  localparam int SETTLE = 8;
  localparam int LOCKN  = 16;
  localparam int MAXS   = 10;
  localparam int ERRL   = 4;
  localparam logic [9:0] T_WORD  = 10'h3a6;
  localparam logic [9:0] FE_WORD = 10'h3aa;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            start = 1'b0;
  logic [3:0][9:0] s_data;
  logic [9:0]      s_sync;
  logic            s_valid;
  logic [4:0]      bitslip;
  logic [4:0]      lane_locked;
  logic            busy;
  logic            fail;
  logic            stream_enable;
  logic [15:0]     relock_count;

  python_align_ctrl #(
    .SETTLE_WORDS (SETTLE),
    .LOCK_COUNT   (LOCKN),
    .MAX_SLIPS    (MAXS),
    .ERR_LIMIT    (ERRL)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .start         (start),
    .s_data        (s_data),
    .s_sync        (s_sync),
    .s_valid       (s_valid),
    .bitslip       (bitslip),
    .lane_locked   (lane_locked),
    .busy          (busy),
    .fail          (fail),
    .stream_enable (stream_enable),
    .relock_count  (relock_count)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [9:0] legal [10] = '{10'h3a6, 10'h22a,
    10'h015, 10'h12a, 10'h32a, 10'h2aa, 10'h3aa,
    10'h0aa, 10'h035, 10'h059};

  int         off [5];
  int         slips [5];
  int         vs [5];
  bit         had [5];
  int         lock_v [5];
  int         lock_c [5];
  bit         rnd4 = 0;
  bit         force_sync = 0;
  logic [9:0] sync_val = '0;
  int         vmode = 0;
  int         cyc = 0;
  int         vcount = 0;
  logic [4:0] prev_bs = '0;
  logic [4:0] prev_lk = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit is_leg(input logic [9:0] w);
    for (int i = 0; i < 10; i++)
      if (legal[i] == w) return 1'b1;
    return 1'b0;
  endfunction

  // the deserialiser presents the training word
  // rotated right by the lane's current offset
  function automatic logic [9:0] rotr(
    input logic [9:0] w, input int n);
    logic [19:0] d;
    d = {w, w};
    return d[n +: 10];
  endfunction

  function automatic logic [9:0] rand_illegal();
    logic [9:0] r;
    do r = 10'($urandom_range(0, 1023));
    while (is_leg(r));
    return r;
  endfunction

  task automatic drive();
    logic [9:0] r;
    s_valid = (vmode == 0) || (cyc % 3 == 0);
    for (int i = 0; i < 4; i++)
      s_data[i] = rotr(T_WORD, off[i]);
    if (force_sync) s_sync = sync_val;
    else if (rnd4) begin
      do r = 10'($urandom_range(0, 1023));
      while (r == T_WORD);
      s_sync = r;
    end else s_sync = rotr(T_WORD, off[4]);
  endtask

  task automatic step();
    drive();
    @(posedge aclk);
    #1;
    cyc++;
    if (s_valid) vcount++;
    for (int i = 0; i < 5; i++) begin
      if (s_valid) vs[i]++;
      if (bitslip[i]) begin
        slips[i]++;
        if (had[i])
          chk("slip_gap", 32'(vs[i] >= SETTLE), 32'd1);
        had[i] = 1'b1;
        vs[i]  = 0;
        off[i] = (off[i] + 9) % 10;
      end
      if (lane_locked[i] && !prev_lk[i]) begin
        lock_v[i] = vcount;
        lock_c[i] = cyc;
      end
    end
    if (bitslip != 5'd0)
      chk("slip_b2b", 32'(bitslip & prev_bs), 32'd0);
    prev_bs = bitslip;
    prev_lk = lane_locked;
  endtask

  task automatic new_test();
    for (int i = 0; i < 5; i++) begin
      slips[i]  = 0;
      vs[i]     = 0;
      had[i]    = 1'b0;
      lock_v[i] = -1;
      lock_c[i] = -1;
    end
    vcount = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    vcount = 0;
  endtask

  task automatic wait_locked(input int budget);
    for (int n = 0; n < budget && lane_locked !== 5'h1f; n++)
      step();
  endtask

  task automatic go_run();
    step();
    chk("wfe_busy", 32'(busy), 32'd1);
    chk("wfe_se", 32'(stream_enable), 32'd0);
    force_sync = 1'b1;
    sync_val   = FE_WORD;
    step();
    force_sync = 1'b0;
    chk("run_se", 32'(stream_enable), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
  endtask

  int exp_ill;
  int exp_rc;
  bit exp_se;
  logic [9:0] seq [8];

  initial begin
    for (int i = 0; i < 5; i++) off[i] = 0;
    new_test();
    drive();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_bitslip", 32'(bitslip), 32'd0);
    chk("rst_locked", 32'(lane_locked), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_se", 32'(stream_enable), 32'd0);
    chk("rst_relock", 32'(relock_count), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // all lanes already aligned
    new_test();
    do_start();
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (LOCKN - 1) step();
    chk("t1_lock15", 32'(lane_locked), 32'd0);
    step();
    chk("t1_lock16", 32'(lane_locked), 32'h1f);
    go_run();
    chk("t1_slips", 32'(slips[0] + slips[1] + slips[2]
        + slips[3] + slips[4]), 32'd0);

    // lane 2 rotated by three bits
    off[2] = 3;
    new_test();
    do_start();
    wait_locked(300);
    chk("t2_locked", 32'(lane_locked), 32'h1f);
    chk("t2_slip2", 32'(slips[2]), 32'd3);
    chk("t2_slip_oth", 32'(slips[0] + slips[1]
        + slips[3] + slips[4]), 32'd0);
    chk("t2_lock0_v", 32'(lock_v[0]), 32'(LOCKN));
    chk("t2_last", 32'(lock_c[2] > lock_c[0]), 32'd1);
    go_run();

    // same rotation, s_valid every third cycle
    off[2] = 3;
    vmode  = 3;
    new_test();
    do_start();
    wait_locked(900);
    vmode = 0;
    chk("t3_locked", 32'(lane_locked), 32'h1f);
    chk("t3_slip2", 32'(slips[2]), 32'd3);
    chk("t3_lock0_v", 32'(lock_v[0]), 32'(LOCKN));
    chk("t3_lock0_c", 32'(lock_c[0] >= 3 * LOCKN - 3),
        32'd1);
    go_run();

    // sync errors in RUN: 3 illegal, 1 legal, 4 illegal
    for (int k = 0; k < 8; k++)
      seq[k] = (k == 3)
             ? legal[$urandom_range(0, 9)]
             : rand_illegal();
    exp_ill = 0;
    exp_rc  = 0;
    exp_se  = 1'b1;
    force_sync = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sync_val = seq[k];
      step();
      if (exp_se) begin
        exp_ill = is_leg(seq[k]) ? 0 : exp_ill + 1;
        if (exp_ill == ERRL) begin
          exp_se = 1'b0;
          exp_rc++;
        end
      end
      chk("t4_se", 32'(stream_enable), 32'(exp_se));
      chk("t4_relock", 32'(relock_count), 32'(exp_rc));
    end
    force_sync = 1'b0;
    chk("t4_busy", 32'(busy), 32'd1);

    // sync lane never trains: runs out of slips
    rnd4 = 1'b1;
    new_test();
    for (int n = 0; n < 500 && fail !== 1'b1; n++)
      step();
    chk("t5_fail", 32'(fail), 32'd1);
    chk("t5_slip4", 32'(slips[4]), 32'(MAXS));
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_se", 32'(stream_enable), 32'd0);
    rnd4   = 1'b0;
    off[4] = 2;
    new_test();
    do_start();
    chk("t5_rs_fail", 32'(fail), 32'd0);
    chk("t5_rs_busy", 32'(busy), 32'd1);
    chk("t5_rs_lock", 32'(lane_locked), 32'd0);
    wait_locked(300);
    chk("t5_rs_locked", 32'(lane_locked), 32'h1f);
    chk("t5_rs_slip4", 32'(slips[4]), 32'd2);
    chk("t5_rs_fail2", 32'(fail), 32'd0);
    go_run();

    // reset while a slip pulse is high
    off[1] = 4;
    new_test();
    do_start();
    for (int n = 0; n < 50 && bitslip[1] !== 1'b1; n++)
      step();
    chk("t6_slip_seen", 32'(bitslip[1]), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_bitslip", 32'(bitslip), 32'd0);
    chk("t6_locked", 32'(lane_locked), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_fail", 32'(fail), 32'd0);
    chk("t6_se", 32'(stream_enable), 32'd0);
    chk("t6_relock", 32'(relock_count), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    prev_bs = '0;
    new_test();
    repeat (30) step();
    chk("t6_idle_slips", 32'(slips[0] + slips[1]
        + slips[2] + slips[3] + slips[4]), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_lock", 32'(lane_locked), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
